// File: rtl/times_table_arbiter_pkg.sv
// Shared widths and types for the times-table arbiter: operand/address/data
// sizes, requester identifiers and the in-flight read tag.
package times_table_arbiter_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 6;
  localparam int OPND_W = 3;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_e;

  typedef struct packed {
    logic    valid;
    req_id_e id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: grants a lone requester directly, breaks ties
// with the priority pointer, and hands priority to the other side after a grant.
module rr_arbiter2
  import times_table_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       enable_i,
  input  req_id_e    ptr_i,
  output logic [1:0] gnt_o,
  output req_id_e    ptr_next_o
);

  always_comb begin
    gnt_o      = 2'b00;
    ptr_next_o = ptr_i;
    if (enable_i) begin
      if (req_i == 2'b11) begin
        gnt_o = (ptr_i == REQ0) ? 2'b01 : 2'b10;
      end else begin
        gnt_o = req_i;
      end
    end
    // Priority always moves away from whoever was just served.
    if (gnt_o[0]) begin
      ptr_next_o = REQ1;
    end else if (gnt_o[1]) begin
      ptr_next_o = REQ0;
    end
  end

endmodule

// File: rtl/times_table_arbiter.sv
// Shares one single-port times-table memory between two requesters and
// routes each read result back to its issuer through a tag shift register.
module times_table_arbiter
  import times_table_arbiter_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              req0,
  input  logic [OPND_W-1:0] a0,
  input  logic [OPND_W-1:0] b0,
  output logic              gnt0,
  output logic              rsp_valid0,
  input  logic              req1,
  input  logic [OPND_W-1:0] a1,
  input  logic [OPND_W-1:0] b1,
  output logic              gnt1,
  output logic              rsp_valid1,
  output logic [DATA_W-1:0] result,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  logic [1:0]        gnt;
  logic              grantAny;
  req_id_e           grantId;
  req_id_e           ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  tag_t              tag_q [READ_LATENCY];
  tag_t              lastTag;
  logic              pipeActive;
  logic              busyAny;

  // Holding the arbiter off during reset keeps grants and the pointer quiet.
  rr_arbiter2 u_arb (
    .req_i      ({req1, req0}),
    .enable_i   (enable & ~rst),
    .ptr_i      (ptr_q),
    .gnt_o      (gnt),
    .ptr_next_o (ptr_d)
  );

  assign grantAny = |gnt;
  assign grantId  = gnt[1] ? REQ1 : REQ0;
  assign lastTag  = tag_q[READ_LATENCY-1];

  always_comb begin
    addr_d = addr_q;
    if (grantAny) begin
      addr_d = gnt[1] ? {a1, b1} : {a0, b0};
    end
  end

  // Every stage but the last still needs a memory edge to move its data along.
  always_comb begin
    pipeActive = 1'b0;
    busyAny    = 1'b0;
    for (int i = 0; i < READ_LATENCY - 1; i++) begin
      pipeActive = pipeActive | tag_q[i].valid;
    end
    for (int i = 0; i < READ_LATENCY; i++) begin
      busyAny = busyAny | tag_q[i].valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= REQ0;
      addr_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      ptr_q    <= ptr_d;
      addr_q   <= addr_d;
      tag_q[0] <= tag_t'{valid: grantAny, id: grantId};
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign gnt0       = gnt[0];
  assign gnt1       = gnt[1];
  assign rsp_valid0 = ~rst & lastTag.valid & (lastTag.id == REQ0);
  assign rsp_valid1 = ~rst & lastTag.valid & (lastTag.id == REQ1);
  assign result     = (~rst & lastTag.valid) ? mem_dout : '0;
  assign mem_en     = ~rst & (grantAny | pipeActive);
  assign mem_addr   = rst ? '0 : addr_d;
  assign busy       = ~rst & busyAny;

endmodule

// File: tb/tb_times_table_arbiter.sv
// Drives two arbiter instances (read latency 1 and 2) with identical traffic
// and scores grants, memory controls and tagged responses against a model.
module tb_times_table_arbiter;

  typedef struct {
    int inst;
    int id;
    int value;
    int due;
  } sbItem_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       req0, req1;
  logic [2:0] a0, b0, a1, b1;

  logic       gnt0 [2];
  logic       gnt1 [2];
  logic       rspValid0 [2];
  logic       rspValid1 [2];
  logic       memEn [2];
  logic       busy [2];
  logic [5:0] result [2];
  logic [5:0] memAddr [2];
  logic [5:0] memDout [2];

  logic [5:0] m1Q  = '0;
  logic [5:0] m2Q0 = '0;
  logic [5:0] m2Q1 = '0;

  int         cyc = 0;
  int         checkCount = 0;
  int         errorCount = 0;
  int         ptrModel = 0;
  logic [5:0] lastAddr = '0;
  int         sweepResp = 0;
  sbItem_t    sbQ [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  times_table_arbiter #(.READ_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .enable(enable),
    .req0(req0), .a0(a0), .b0(b0), .gnt0(gnt0[0]), .rsp_valid0(rspValid0[0]),
    .req1(req1), .a1(a1), .b1(b1), .gnt1(gnt1[0]), .rsp_valid1(rspValid1[0]),
    .result(result[0]), .mem_en(memEn[0]), .mem_addr(memAddr[0]),
    .mem_dout(memDout[0]), .busy(busy[0])
  );

  times_table_arbiter #(.READ_LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst), .enable(enable),
    .req0(req0), .a0(a0), .b0(b0), .gnt0(gnt0[1]), .rsp_valid0(rspValid0[1]),
    .req1(req1), .a1(a1), .b1(b1), .gnt1(gnt1[1]), .rsp_valid1(rspValid1[1]),
    .result(result[1]), .mem_en(memEn[1]), .mem_addr(memAddr[1]),
    .mem_dout(memDout[1]), .busy(busy[1])
  );

  function automatic logic [5:0] tableEntry(input logic [5:0] addr);
    int p;
    p = int'(addr[5:3]) * int'(addr[2:0]);
    return p[5:0];
  endfunction

  // Memory models: one unregistered-output stage, and one with an output register.
  always @(posedge clk) begin
    if (memEn[0]) m1Q <= tableEntry(memAddr[0]);
    if (memEn[1]) begin
      m2Q0 <= tableEntry(memAddr[1]);
      m2Q1 <= m2Q0;
    end
  end
  assign memDout[0] = m1Q;
  assign memDout[1] = m2Q1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Scoreboard monitor: checks every cycle away from the active edge.
  always @(negedge clk) begin
    int         pending;
    logic       nonLast;
    int         frontIdx;
    logic       expG0, expG1;
    logic [5:0] expAddr;
    logic [1:0] expRv;
    int         expVal;
    sbItem_t    item;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        checkOutput("rstGnt", {30'd0, gnt1[k], gnt0[k]}, 0);
        checkOutput("rstRsp", {30'd0, rspValid1[k], rspValid0[k]}, 0);
        checkOutput("rstMemEn", {31'd0, memEn[k]}, 0);
        checkOutput("rstBusy", {31'd0, busy[k]}, 0);
        checkOutput("rstAddr", {26'd0, memAddr[k]}, 0);
      end
      sbQ.delete();
      ptrModel = 0;
      lastAddr = '0;
    end else begin
      expG0 = 1'b0;
      expG1 = 1'b0;
      if (enable) begin
        if (req0 && req1) begin
          expG0 = (ptrModel == 0);
          expG1 = (ptrModel == 1);
        end else begin
          expG0 = req0;
          expG1 = req1;
        end
      end
      expAddr = expG1 ? {a1, b1} : {a0, b0};
      expVal  = expG1 ? int'(a1) * int'(b1) : int'(a0) * int'(b0);
      for (int k = 0; k < 2; k++) begin
        pending  = 0;
        nonLast  = 1'b0;
        frontIdx = -1;
        for (int j = 0; j < sbQ.size(); j++) begin
          if (sbQ[j].inst == k) begin
            pending++;
            if (sbQ[j].due > cyc) nonLast = 1'b1;
            if (frontIdx < 0) frontIdx = j;
          end
        end
        checkOutput("gnt0", {31'd0, gnt0[k]}, {31'd0, expG0});
        checkOutput("gnt1", {31'd0, gnt1[k]}, {31'd0, expG1});
        checkOutput("busy", {31'd0, busy[k]}, {31'd0, pending > 0});
        checkOutput("memEn", {31'd0, memEn[k]}, {31'd0, expG0 | expG1 | nonLast});
        checkOutput("memAddr", {26'd0, memAddr[k]}, {26'd0, (expG0 | expG1) ? expAddr : lastAddr});
        expRv = 2'b00;
        if (frontIdx >= 0 && sbQ[frontIdx].due == cyc) begin
          expRv = (sbQ[frontIdx].id == 1) ? 2'b10 : 2'b01;
        end
        checkOutput("rspValid", {30'd0, rspValid1[k], rspValid0[k]}, {30'd0, expRv});
        if (expRv != 2'b00) begin
          checkOutput("result", {26'd0, result[k]}, sbQ[frontIdx].value);
          if (k == 0 && rspValid0[k]) sweepResp++;
          sbQ.delete(frontIdx);
        end
        if (expG0 | expG1) begin
          item.inst  = k;
          item.id    = expG1 ? 1 : 0;
          item.value = expVal;
          item.due   = cyc + k + 1;
          sbQ.push_back(item);
        end
      end
      if (expG0 | expG1) begin
        ptrModel = expG0 ? 1 : 0;
        lastAddr = expAddr;
      end
    end
  end

  task automatic applyStimulus(input logic r0, input logic [2:0] x0, input logic [2:0] y0,
                               input logic r1, input logic [2:0] x1, input logic [2:0] y1,
                               input logic en);
    req0   = r0;
    a0     = x0;
    b0     = y0;
    req1   = r1;
    a1     = x1;
    b1     = y1;
    enable = en;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         idx;
    int         guard;
    logic       got;
    logic [5:0] pair;
    rst    = 1'b1;
    enable = 1'b0;
    req0   = 1'b0;
    req1   = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Contention straight out of reset: requester 0 wins first.
    repeat (4) applyStimulus(1, 3'd7, 3'd7, 1, 3'd2, 3'd6, 1);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 1);

    // Single read of 3*5.
    applyStimulus(1, 3'd3, 3'd5, 0, 0, 0, 1);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 1);

    // Back-to-back reads from requester 1.
    for (int i = 1; i <= 3; i++) applyStimulus(0, 0, 0, 1, 3'd4, 3'(i), 1);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 1);

    // Enable gating, then release.
    repeat (3) applyStimulus(1, 3'd6, 3'd3, 0, 0, 0, 0);
    applyStimulus(1, 3'd6, 3'd3, 0, 0, 0, 1);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 1);

    // Reset while a read is in flight.
    applyStimulus(1, 3'd5, 3'd5, 0, 0, 0, 1);
    rst = 1'b1;
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 1);
    rst = 1'b0;
    repeat (2) applyStimulus(1, 3'd1, 3'd2, 1, 3'd3, 3'd4, 1);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 1);

    // Requester 0 walks the whole table while requester 1 competes randomly.
    idx   = 0;
    guard = 0;
    while (idx < 64 && guard < 1000) begin
      pair   = idx[5:0];
      req0   = 1'b1;
      a0     = pair[5:3];
      b0     = pair[2:0];
      req1   = 1'($urandom_range(0, 1));
      a1     = 3'($urandom_range(0, 7));
      b1     = 3'($urandom_range(0, 7));
      enable = 1'b1;
      @(negedge clk);
      got = gnt0[0];
      @(posedge clk);
      #1;
      if (got) idx++;
      guard++;
    end
    checkOutput("sweepIssued", idx, 64);
    repeat (6) applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("sweepResp", sweepResp >= 64, 1);
    checkOutput("drained", sbQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
